// File: rtl/demux16_route_if.sv
// demux16_route_if: bundles the source handshake and the three destination
// channel handshakes of the demux16_route routing demultiplexer.
// master = the surrounding datapath (drives source, consumes channels);
// slave  = the demultiplexer itself.
interface demux16_route_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] in_data;
  logic [1:0]       in_sel;
  logic             in_valid;
  logic             in_ready;

  logic [WIDTH-1:0] out_a_data;
  logic             out_a_valid;
  logic             out_a_ready;
  logic [WIDTH-1:0] out_b_data;
  logic             out_b_valid;
  logic             out_b_ready;
  logic [WIDTH-1:0] out_c_data;
  logic             out_c_valid;
  logic             out_c_ready;

  modport master (
    output in_data, in_sel, in_valid, out_a_ready, out_b_ready, out_c_ready,
    input  in_ready, out_a_data, out_a_valid, out_b_data, out_b_valid,
           out_c_data, out_c_valid
  );

  modport slave (
    input  in_data, in_sel, in_valid, out_a_ready, out_b_ready, out_c_ready,
    output in_ready, out_a_data, out_a_valid, out_b_data, out_b_valid,
           out_c_data, out_c_valid
  );
endinterface

// File: rtl/demux16_route.sv
// demux16_route: routes one source word to channel A, B or C (sel 00/01/1x).
// Each channel is a one-entry registered buffer with valid/ready, so each
// destination can stall on its own while the others keep flowing.
// Optional macro DEMUX16_ROUTE_COUNT_EN adds per-channel accept counters
// (cnt_clr, cnt_a, cnt_b, cnt_c).
module demux16_route #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_f,
  demux16_route_if.slave   bus
`ifdef DEMUX16_ROUTE_COUNT_EN
  ,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] cnt_a,
  output logic [CNT_W-1:0] cnt_b,
  output logic [CNT_W-1:0] cnt_c
`endif
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } chan_state_t;

  logic [2:0]       sel_onehot;
  logic [2:0]       ready_vec;
  logic [2:0]       full_vec;
  logic [2:0]       fill_vec;
  logic             accept;
  logic [WIDTH-1:0] data_vec [3];

  // Decode the select into a one-hot target; 10 and 11 both go to C.
  always_comb begin
    sel_onehot = 3'b000;
    case (bus.in_sel)
      2'b00:   sel_onehot = 3'b001;
      2'b01:   sel_onehot = 3'b010;
      default: sel_onehot = 3'b100;
    endcase
  end

  assign ready_vec = {bus.out_c_ready, bus.out_b_ready, bus.out_a_ready};

  // The target can take a word if it is empty or is being drained this cycle.
  assign bus.in_ready = |(sel_onehot & (~full_vec | ready_vec));
  assign accept       = bus.in_valid & bus.in_ready;
  assign fill_vec     = sel_onehot & {3{accept}};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_chan
      chan_state_t      state_reg;
      chan_state_t      state_next;
      logic [WIDTH-1:0] data_reg;
      logic [WIDTH-1:0] data_next;

      // Next state: a fill wins over a drain, so fill+drain stays FULL.
      always_comb begin
        state_next = state_reg;
        data_next  = data_reg;
        if (fill_vec[gi]) begin
          state_next = FULL;
          data_next  = bus.in_data;
        end else if (state_reg == FULL && ready_vec[gi]) begin
          state_next = EMPTY;
        end
      end

      // Channel buffer register; reset discards any buffered word.
      always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
          state_reg <= EMPTY;
          data_reg  <= '0;
        end else begin
          state_reg <= state_next;
          data_reg  <= data_next;
        end
      end

      assign full_vec[gi] = (state_reg == FULL);
      assign data_vec[gi] = data_reg;

`ifdef DEMUX16_ROUTE_COUNT_EN
      logic [CNT_W-1:0] cnt_reg;

      // Count accepts into this channel; clear has priority, wraps naturally.
      always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
          cnt_reg <= '0;
        end else if (cnt_clr) begin
          cnt_reg <= '0;
        end else if (fill_vec[gi]) begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end
`endif
    end
  endgenerate

  assign bus.out_a_data  = data_vec[0];
  assign bus.out_b_data  = data_vec[1];
  assign bus.out_c_data  = data_vec[2];
  assign bus.out_a_valid = full_vec[0];
  assign bus.out_b_valid = full_vec[1];
  assign bus.out_c_valid = full_vec[2];

`ifdef DEMUX16_ROUTE_COUNT_EN
  assign cnt_a = g_chan[0].cnt_reg;
  assign cnt_b = g_chan[1].cnt_reg;
  assign cnt_c = g_chan[2].cnt_reg;
`endif

endmodule

// File: tb/tb_demux16_route.sv
// tb_demux16_route: directed vectors for demux16_route with hand-computed
// expectations. Inputs change on the falling edge; outputs are sampled on
// the falling edge or shortly after an input change.
module tb_demux16_route;
  localparam int WIDTH = 16;
  localparam int CNT_W = 8;

  logic clk;
  logic rst_f;
  int   n_cmp;
  int   n_bad;

  demux16_route_if #(.WIDTH(WIDTH)) bus ();

`ifdef DEMUX16_ROUTE_COUNT_EN
  logic             cnt_clr;
  logic [CNT_W-1:0] cnt_a;
  logic [CNT_W-1:0] cnt_b;
  logic [CNT_W-1:0] cnt_c;
`endif

  demux16_route #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk     (clk),
    .rst_f   (rst_f),
    .bus     (bus)
`ifdef DEMUX16_ROUTE_COUNT_EN
    ,
    .cnt_clr (cnt_clr),
    .cnt_a   (cnt_a),
    .cnt_b   (cnt_b),
    .cnt_c   (cnt_c)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] sel, input logic [15:0] d);
    bus.in_valid = v;
    bus.in_sel   = sel;
    bus.in_data  = d;
  endtask

  logic [15:0] cwords [4];

  initial begin
    n_cmp = 0;
    n_bad = 0;
    cwords[0] = 16'hC001; cwords[1] = 16'hC002;
    cwords[2] = 16'hC003; cwords[3] = 16'hC004;
    rst_f = 1'b0;
    drive(1'b0, 2'b00, 16'h0000);
    bus.out_a_ready = 1'b1;
    bus.out_b_ready = 1'b1;
    bus.out_c_ready = 1'b1;
`ifdef DEMUX16_ROUTE_COUNT_EN
    cnt_clr = 1'b0;
`endif

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_a_valid", 32'(bus.out_a_valid), 32'd0);
    check("rst_b_valid", 32'(bus.out_b_valid), 32'd0);
    check("rst_c_valid", 32'(bus.out_c_valid), 32'd0);
    check("rst_b_data",  32'(bus.out_b_data),  32'h0);
    check("rst_in_ready", 32'(bus.in_ready),   32'd1);
    rst_f = 1'b1;
    @(negedge clk);

    // Single word to B
    drive(1'b1, 2'b01, 16'hBEEF);
    #1 check("beef_in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    check("beef_b_valid", 32'(bus.out_b_valid), 32'd1);
    check("beef_b_data",  32'(bus.out_b_data),  32'hBEEF);
    check("beef_a_valid", 32'(bus.out_a_valid), 32'd0);
    check("beef_c_valid", 32'(bus.out_c_valid), 32'd0);
    drive(1'b0, 2'b00, 16'h0000);
    @(negedge clk);
    check("beef_b_drained", 32'(bus.out_b_valid), 32'd0);

    // A stalled: 1111 buffered, 2222 blocked
    bus.out_a_ready = 1'b0;
    drive(1'b1, 2'b00, 16'h1111);
    @(negedge clk);
    check("a1_valid", 32'(bus.out_a_valid), 32'd1);
    check("a1_data",  32'(bus.out_a_data),  32'h1111);
    drive(1'b1, 2'b00, 16'h2222);
    #1 check("a2_stall_ready", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    check("a2_hold_data", 32'(bus.out_a_data), 32'h1111);

    // Re-target to C while A stalls
    drive(1'b1, 2'b11, 16'h3333);
    #1 check("c3_in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    check("c3_c_valid", 32'(bus.out_c_valid), 32'd1);
    check("c3_c_data",  32'(bus.out_c_data),  32'h3333);
    check("c3_a_data",  32'(bus.out_a_data),  32'h1111);
    check("c3_a_valid", 32'(bus.out_a_valid), 32'd1);

    // Release A: drain 1111 and accept 2222 in the same cycle
    drive(1'b1, 2'b00, 16'h2222);
    #1 check("a2_still_blocked", 32'(bus.in_ready), 32'd0);
    bus.out_a_ready = 1'b1;
    #1 check("a2_ready_on_drain", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    check("a2_valid", 32'(bus.out_a_valid), 32'd1);
    check("a2_data",  32'(bus.out_a_data),  32'h2222);
    check("a2_c_drained", 32'(bus.out_c_valid), 32'd0);
    drive(1'b0, 2'b00, 16'h0000);
    @(negedge clk);
    check("a2_drained", 32'(bus.out_a_valid), 32'd0);

    // Back-to-back burst to C, no bubbles
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 2'b10, cwords[i]);
      #1 check($sformatf("burst%0d_ready", i), 32'(bus.in_ready), 32'd1);
      @(negedge clk);
      check($sformatf("burst%0d_valid", i), 32'(bus.out_c_valid), 32'd1);
      check($sformatf("burst%0d_data", i),  32'(bus.out_c_data),  32'(cwords[i]));
    end
    drive(1'b0, 2'b00, 16'h0000);
    @(negedge clk);
    check("burst_end_valid", 32'(bus.out_c_valid), 32'd0);

    // Async reset mid-cycle while B holds ABCD
    bus.out_b_ready = 1'b0;
    drive(1'b1, 2'b01, 16'hABCD);
    @(negedge clk);
    drive(1'b0, 2'b00, 16'h0000);
    check("abcd_b_valid", 32'(bus.out_b_valid), 32'd1);
    check("abcd_b_data",  32'(bus.out_b_data),  32'hABCD);
    #2 rst_f = 1'b0;
    #1 check("arst_b_valid", 32'(bus.out_b_valid), 32'd0);
    check("arst_b_data", 32'(bus.out_b_data), 32'h0);
    @(negedge clk);
    rst_f = 1'b1;
    bus.out_b_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("arst_lost%0d", i), 32'(bus.out_b_valid), 32'd0);
    end

`ifdef DEMUX16_ROUTE_COUNT_EN
    // 257 accepts to A wrap an 8-bit counter to 1
    check("cnt_a_zero", 32'(cnt_a), 32'd0);
    drive(1'b1, 2'b00, 16'h5A5A);
    repeat (257) @(negedge clk);
    drive(1'b0, 2'b00, 16'h0000);
    check("cnt_a_wrap", 32'(cnt_a), 32'd1);
    check("cnt_b_idle", 32'(cnt_b), 32'd0);
    check("cnt_c_idle", 32'(cnt_c), 32'd0);
    // Clear beats a simultaneous accept
    drive(1'b1, 2'b00, 16'h6666);
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    check("cnt_clr_prio", 32'(cnt_a), 32'd0);
    check("cnt_clr_data", 32'(bus.out_a_data), 32'h6666);
    @(negedge clk);
    drive(1'b0, 2'b00, 16'h0000);
    check("cnt_after_clr", 32'(cnt_a), 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/demux16_route.md
Name: demux16_route

Overview:
- 16-bit routing demultiplexer for the SISC datapath; the distribution counterpart of the 3-input datapath select mux.
- Takes one source word plus a 2-bit select and delivers it to one of three destination channels (A, B, C).
- Each channel has a one-entry registered output buffer with a valid/ready handshake, so destinations can stall independently.

Parameters:
- WIDTH, 16, data width of input and each output channel.
- CNT_W, 8, width of per-channel transfer counters (used only with the optional feature).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_f  input  1  asynchronous active-low reset.
- in_data  input  WIDTH  source word.
- in_sel  input  2  destination select: 00=A, 01=B, 10=C, 11=C.
- in_valid  input  1  source word present.
- in_ready  output  1  block accepts the source word this cycle.
- out_a_data  output  WIDTH  channel A word.
- out_a_valid  output  1  channel A buffer full.
- out_a_ready  input  1  channel A consumer accepts.
- out_b_data / out_b_valid / out_b_ready: as channel A, for B.
- out_c_data / out_c_valid / out_c_ready: as channel A, for C.

Behaviour:
- Reset (rst_f=0, asynchronous): all out_x_valid=0, all out_x_data=0; in_ready then follows the combinational rule below. Words buffered when reset asserts are discarded; no partial transfer survives.
- Per-channel state machine, two states:
  - EMPTY: out_x_valid=0.
  - FULL: out_x_valid=1, out_x_data holds the word.
- Target channel T = decode(in_sel); 10 and 11 both select C.
- in_ready is combinational: in_ready = (T is EMPTY) OR (T is FULL AND out_T_ready=1). in_ready does not depend on in_valid.
- Accept: in_valid & in_ready at the rising edge. The word is written into T's buffer; T is FULL next cycle. Latency is 1 cycle from accept to out_T_valid.
- Drain: out_x_valid & out_x_ready at the edge. Channel x goes to EMPTY unless it is filled in the same cycle.
- Simultaneous drain and fill on the same channel: the channel stays FULL with the new word. Full throughput is one word per cycle to a single channel.
- Channels operate independently. A fill of one channel and drains of the others may occur in the same cycle.
- While out_x_valid=1 and out_x_ready=0, out_x_data is held stable.
- When in_valid=0 or in_ready=0, no channel state changes except drains.
- in_sel and in_data are sampled only on an accept cycle. Changing in_sel while stalled is legal and re-evaluates in_ready against the new target.
- No data transformation; bit-exact copy. Data of a non-targeted channel never changes.

Optional Feature:
- Macro: DEMUX16_ROUTE_COUNT_EN.
- Defined:
  - Adds ports cnt_clr (input, 1), cnt_a, cnt_b, cnt_c (output, CNT_W each).
  - cnt_x increments by 1 on each accept into channel x, counting accepts rather than drains.
  - Counters wrap from 2^CNT_W-1 to 0.
  - cnt_clr=1 zeroes all counters synchronously and takes priority over an increment in the same cycle.
  - rst_f=0 zeroes all counters.
- Undefined: none of these ports or registers exist; the routing behaviour is identical.

Test Plan:
- Reset release, all out ready=1, in_valid=1, in_sel=01, in_data=16'hBEEF -> next cycle out_b_valid=1, out_b_data=BEEF; out_a_valid=0, out_c_valid=0.
- out_a_ready=0; send 16'h1111 to A, then 16'h2222 to A -> second word stalls (in_ready=0) and A holds 1111. Raise out_a_ready -> 1111 drains and 2222 is accepted the same cycle, then appears on A.
- A stalled and FULL; send 16'h3333 with in_sel=11 -> in_ready=1, out_c_data=3333 next cycle; A unchanged.
- Back-to-back 4 words to C, out_c_ready=1 -> 4 consecutive cycles of out_c_valid=1 with data in order, with no bubble.
- Assert rst_f=0 while B FULL with 16'hABCD, asynchronously mid-cycle -> out_b_valid=0 and out_b_data=0 immediately; after release the word is never delivered.
- With DEMUX16_ROUTE_COUNT_EN and CNT_W=8: 257 accepts to A -> cnt_a=1. cnt_clr=1 together with an accept -> cnt_a=0 next cycle.
